alu_sweep_sequencer: RTL

//  Upstream issue stage for the 4-bit ALU. Accepts one operand pair (a,b) per valid/ready handshake.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_out_slot.sv | 42 ++++
 rtl/alu_sweep_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU sweep sequencer slice.
package alu_pkg;

   localparam int DATA_W = 4;
   localparam int SEL_W  = 4;
   localparam int RES_W  = 6;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/alu_out_slot.sv
// One-entry result register with valid/ready on its output side.
// A capture loads a new result, flush empties the slot, and a consumed
// result clears valid when nothing new is captured in the same cycle.
module alu_out_slot #(
   parameter int SEL_W = alu_pkg::SEL_W,
   parameter int RES_W = alu_pkg::RES_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             capture,
   input  logic [SEL_W-1:0] cap_sel,
   input  logic [RES_W-1:0] cap_y,
   input  logic             cap_last,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [SEL_W-1:0] out_sel,
   output logic [RES_W-1:0] out_y,
   output logic             out_last
);

   // Slot contents: flush wins, then a new capture, then a plain drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sel   <= '0;
         out_y     <= '0;
         out_last  <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         out_sel   <= cap_sel;
         out_y     <= cap_y;
         out_last  <= cap_last;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_sweep_sequencer.sv
// Issue stage for the 4-bit ALU: takes one operand pair, then walks the
// opcode from SEL_FIRST to SEL_LAST one per cycle, forwarding every ALU
// result downstream. The ALU sits outside, between alu_* and alu_y.
module alu_sweep_sequencer #(
   parameter int DATA_W    = alu_pkg::DATA_W,
   parameter int SEL_W     = alu_pkg::SEL_W,
   parameter int RES_W     = alu_pkg::RES_W,
   parameter int SEL_FIRST = 0,
   parameter int SEL_LAST  = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [SEL_W-1:0]  alu_sel,
   input  logic [RES_W-1:0]  alu_y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SEL_W-1:0]  out_sel,
   output logic [RES_W-1:0]  out_y,
   output logic              out_last,
   output logic              busy
);

   import alu_pkg::*;

   localparam logic [SEL_W-1:0] SEL_FIRST_V = SEL_W'(SEL_FIRST);
   localparam logic [SEL_W-1:0] SEL_LAST_V  = SEL_W'(SEL_LAST);

   // A sweep that runs backwards makes no sense; refuse to build it.
   generate
      if (SEL_FIRST > SEL_LAST) begin : g_bad_sel_range
         $error("alu_sweep_sequencer: SEL_FIRST must not exceed SEL_LAST");
      end
   endgenerate

   seq_state_t state;
   seq_state_t state_next;

   logic accept;
   logic slot_free;
   logic capture;
   logic at_last;

   assign in_ready  = (state == IDLE) && !flush;
   assign accept    = in_valid && in_ready;
   assign slot_free = !out_valid || out_ready;
   assign capture   = (state == RUN) && slot_free && !flush;
   assign at_last   = (alu_sel == SEL_LAST_V);
   assign busy      = (state == RUN);

   // State register for the IDLE/RUN sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: start on an accepted pair, stop once the last opcode's result is captured.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (capture && at_last) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
      if (flush) begin
         state_next = IDLE;
      end
   end

   // Operand latch and opcode counter; the counter only advances when a result is captured,
   // so a downstream stall freezes the ALU inputs and no opcode is skipped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= SEL_FIRST_V;
      end else if (flush) begin
         alu_sel <= SEL_FIRST_V;
      end else if (accept) begin
         alu_a   <= in_a;
         alu_b   <= in_b;
         alu_sel <= SEL_FIRST_V;
      end else if (capture && !at_last) begin
         alu_sel <= alu_sel + 1'b1;
      end
   end

   alu_out_slot #(
      .SEL_W (SEL_W),
      .RES_W (RES_W)
   ) u_out_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .capture   (capture),
      .cap_sel   (alu_sel),
      .cap_y     (alu_y),
      .cap_last  (at_last),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_sel   (out_sel),
      .out_y     (out_y),
      .out_last  (out_last)
   );

endmodule
